// File: rtl/sequenciador_pkg.sv
// Shared types and constants for the display sequencer.
// A word is {5-bit character, parity bit}; the parity bit sits at index 0.
package sequenciador_pkg;

    localparam int unsigned WORD_W     = 6;
    localparam int unsigned CHAR_W     = 5;
    localparam int unsigned PARITY_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        DONE,
        HALT
    } state_t;

endpackage

// File: rtl/temporizador_exibicao.sv
// Hold timer: counts display cycles for the current word and ticks on the last one.
// The count stays at 0 while restart is high and wraps to 0 after each tick.
module temporizador_exibicao #(
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] hold_q;

    assign tick = run && (hold_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (restart) begin
            hold_q <= '0;
        end else if (run) begin
            hold_q <= tick ? '0 : hold_q + CW'(1);
        end
    end

endmodule

// File: rtl/sequenciador_display.sv
// Buffers words through a valid/ready port and plays them back onto the parity/7-seg datapath.
// Optional STOP_ON_ERROR_EN: a parity error parks playback in HALT until start resumes it.
module sequenciador_display
    import sequenciador_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned ERR_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [WORD_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       start,
    input  logic                       clr,
    input  logic                       loop_en,
    input  logic                       erro,
    output logic [WORD_W-1:0]          palavra,
    output logic                       palavra_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [ERR_W-1:0]           err_count,
    output logic                       done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t              state_q, state_d, adv_state;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d, adv_idx;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [WORD_W-1:0]   palavra_q, palavra_d;
    logic                valid_q, valid_d, adv_valid;
    logic                wr_en, tick, is_last;
    logic [WORD_W-1:0]   mem [DEPTH];

    temporizador_exibicao #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state_q == SHOW),
        .restart(clr || (state_q != SHOW)),
        .tick   (tick)
    );

    assign wr_ready = (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !clr;
    assign is_last  = (CNT_W'(rd_idx_q) + CNT_W'(1)) == count_q;

    // Where playback goes after the current word: next index, wrap, or finish.
    always_comb begin
        adv_state = SHOW;
        adv_idx   = rd_idx_q + IDX_W'(1);
        adv_valid = 1'b1;
        if (is_last) begin
            if (loop_en) begin
                adv_idx = '0;
            end else begin
                adv_state = DONE;
                adv_idx   = rd_idx_q;
                adv_valid = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_idx_d  = rd_idx_q;
        err_d     = err_q;
        palavra_d = palavra_q;
        valid_d   = valid_q;
        wr_en     = 1'b0;
        if (clr) begin
            state_d  = IDLE;
            count_d  = '0;
            rd_idx_d = '0;
            err_d    = '0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (count_q != '0)) begin
                        state_d   = SHOW;
                        rd_idx_d  = '0;
                        palavra_d = mem[IDX_W'(0)];
                        valid_d   = 1'b1;
                    end else if (wr_valid && wr_ready) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (tick) begin
                        if (erro && (err_q != ERR_MAX)) begin
                            err_d = err_q + ERR_W'(1);
                        end
`ifdef STOP_ON_ERROR_EN
                        if (erro) begin
                            state_d = HALT;
                        end else begin
                            state_d   = adv_state;
                            rd_idx_d  = adv_idx;
                            valid_d   = adv_valid;
                            palavra_d = mem[adv_idx];
                        end
`else
                        state_d   = adv_state;
                        rd_idx_d  = adv_idx;
                        valid_d   = adv_valid;
                        palavra_d = mem[adv_idx];
`endif
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
`ifdef STOP_ON_ERROR_EN
                HALT: begin
                    if (start) begin
                        state_d   = adv_state;
                        rd_idx_d  = adv_idx;
                        valid_d   = adv_valid;
                        palavra_d = mem[adv_idx];
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rd_idx_q  <= '0;
            err_q     <= '0;
            palavra_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_idx_q  <= rd_idx_d;
            err_q     <= err_d;
            palavra_q <= palavra_d;
            valid_q   <= valid_d;
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[IDX_W-1:0]] <= wr_data;
        end
    end

    assign palavra       = palavra_q;
    assign palavra_valid = valid_q;
    assign busy          = (state_q == SHOW) || (state_q == HALT);
    assign count         = count_q;
    assign err_count     = err_q;
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_sequenciador_display.sv
// Directed bench for sequenciador_display with DEPTH=4, HOLD_CYCLES=4.
// The verifier is modelled as an even-parity check over the displayed word.
module tb_sequenciador_display;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [5:0] wr_data = '0;
    logic       wr_ready;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic       loop_en = 1'b0;
    logic       erro;
    logic [5:0] palavra;
    logic       palavra_valid;
    logic       busy;
    logic [2:0] count;
    logic [7:0] err_count;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done;
    logic [5:0] msg [4];

    always #5 clk = ~clk;

    assign erro = palavra_valid & (^palavra);

    sequenciador_display #(
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD),
        .ERR_W      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .start        (start),
        .clr          (clr),
        .loop_en      (loop_en),
        .erro         (erro),
        .palavra      (palavra),
        .palavra_valid(palavra_valid),
        .busy         (busy),
        .count        (count),
        .err_count    (err_count),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [5:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        #3;
        check("rst_count", count, 0);
        check("rst_valid", palavra_valid, 0);
        check("rst_palavra", palavra, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_err", err_count, 0);
        step();
        rst_n = 1'b1;
        step();

        // Basic playback of three even-parity words
        msg[0] = 6'h03; msg[1] = 6'h05; msg[2] = 6'h06; msg[3] = 6'h00;
        for (int i = 0; i < 3; i++) write_word(msg[i]);
        check("t1_count", count, 3);
        pulse_start();
        n_done = 0;
        for (int k = 1; k <= 13; k++) begin
            if (k <= 12) begin
                check($sformatf("t1_pal_c%0d", k), palavra, msg[(k-1)/4]);
                check($sformatf("t1_val_c%0d", k), palavra_valid, 1);
                check($sformatf("t1_done_c%0d", k), done, 0);
            end else begin
                check("t1_done_c13", done, 1);
                check("t1_val_c13", palavra_valid, 0);
            end
            step();
        end
        check("t1_done_after", done, 0);
        check("t1_busy_after", busy, 0);
        check("t1_err", err_count, 0);
        check("t1_count_kept", count, 3);

        // start + write in the same IDLE cycle; start during SHOW ignored
        do_clr();
        check("t5_cleared", count, 0);
        write_word(6'h03);
        write_word(6'h05);
        start = 1'b1; wr_valid = 1'b1; wr_data = 6'h06;
        step();
        start = 1'b0; wr_valid = 1'b0;
        check("t5_count", count, 2);
        check("t5_busy", busy, 1);
        check("t5_pal_c1", palavra, 6'h03);
        pulse_start();
        check("t5_pal_c2", palavra, 6'h03);
        step(); step(); step();
        check("t5_pal_c5", palavra, 6'h05);
        step(); step(); step(); step();
        check("t5_done_c9", done, 1);
        check("t5_count_end", count, 2);
        step();

        // Overflow: fifth word dropped and never shown
        do_clr();
        msg[0] = 6'h03; msg[1] = 6'h05; msg[2] = 6'h06; msg[3] = 6'h0A;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = (i < 4) ? msg[i] : 6'h0C;
            #1;
            check($sformatf("t2_ready_%0d", i), wr_ready, (i < 4) ? 1 : 0);
            step();
        end
        wr_valid = 1'b0;
        check("t2_count", count, 4);
        pulse_start();
        for (int k = 1; k < 13; k++) step();
        check("t2_pal_c13", palavra, 6'h0A);
        step(); step(); step(); step();
        check("t2_done_c17", done, 1);
        check("t2_val_c17", palavra_valid, 0);
        step();

        // Looping with a bad-parity word
        do_clr();
        write_word(6'h01);
        write_word(6'h03);
        loop_en = 1'b1;
        pulse_start();
        n_done = 0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 1 || k == 9) check($sformatf("t3_pal_c%0d", k), palavra, 6'h01);
            if (k == 5) check("t3_pal_c5", palavra, 6'h03);
            if (done) n_done++;
            step();
        end
        check("t3_no_done", n_done, 0);
        check("t3_err", err_count, 3);
        check("t3_pal_c25", palavra, 6'h01);
        do_clr();
        loop_en = 1'b0;
        check("t3_clr_count", count, 0);
        check("t3_clr_err", err_count, 0);
        check("t3_clr_valid", palavra_valid, 0);
        check("t3_clr_busy", busy, 0);

        // Asynchronous reset mid-SHOW
        write_word(6'h03);
        write_word(6'h05);
        pulse_start();
        step(); step();
        rst_n = 1'b0;
        #1;
        check("t4_valid", palavra_valid, 0);
        check("t4_pal", palavra, 0);
        check("t4_busy", busy, 0);
        check("t4_count", count, 0);
        step();
        rst_n = 1'b1;
        pulse_start();
        check("t4_start_ignored_busy", busy, 0);
        check("t4_start_ignored_valid", palavra_valid, 0);

`ifdef STOP_ON_ERROR_EN
        // Halt on bad parity, resume with start
        write_word(6'h03);
        write_word(6'h01);
        write_word(6'h05);
        pulse_start();
        for (int k = 1; k < 15; k++) step();
        check("t6_halt_busy", busy, 1);
        check("t6_halt_valid", palavra_valid, 1);
        check("t6_halt_pal", palavra, 6'h01);
        check("t6_halt_err", err_count, 1);
        pulse_start();
        check("t6_resume_pal", palavra, 6'h05);
        step(); step(); step(); step();
        check("t6_done", done, 1);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sequenciador_display.md
Name: sequenciador_display

Overview:
- Sequencer for the parity-check + 7-segment display datapath.
- Buffers up to DEPTH 6-bit words ({5-bit character, parity bit}) loaded through a valid/ready port.
- On command, plays them back one at a time onto the datapath input, holding each for HOLD_CYCLES.
- Samples the datapath's parity-error flag and counts errors.

Parameters:
- DEPTH, 8, buffer capacity in words (power of 2, ≥2).
- HOLD_CYCLES, 50000000, clock cycles each word stays on the display (≥2).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_data  in  6  word to store: [5:1] character, [0] parity.
- wr_ready  out  1  buffer accepts a write this cycle.
- start  in  1  begin playback (level sampled each cycle).
- clr  in  1  abort playback and empty buffer.
- loop_en  in  1  repeat the message instead of finishing.
- erro  in  1  parity-error flag returned by the verifier for the current palavra.
- palavra  out  6  word driven to the datapath.
- palavra_valid  out  1  palavra is meaningful; display blanks when 0.
- busy  out  1  playback in progress (state SHOW or HALT).
- count  out  $clog2(DEPTH+1)  words stored.
- err_count  out  ERR_W  parity errors seen, saturating.
- done  out  1  one-cycle pulse when a non-looping playback completes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; count=0; rd_idx=0; hold=0; err_count=0.
  - palavra=0; palavra_valid=0; busy=0; done=0; wr_ready=1.
  - Buffer contents are don't-care.
- wr_ready = (state==IDLE) && (count<DEPTH) && !clr. It is combinational.
- A write occurs on wr_valid && wr_ready: buf[count] <= wr_data, count++. Writes are never accepted outside IDLE. With wr_valid asserted while full, the write is dropped and count is unchanged.
- Priority each cycle: clr > start > write. start and write in the same IDLE cycle: start wins and the write is not accepted (wr_ready already 0 is not required, but no store occurs).
- clr, any state: next cycle state=IDLE, count=0, err_count=0, palavra_valid=0, hold=0, rd_idx=0. No done pulse.
- IDLE:
  - start with count==0 is ignored.
  - start with count>0 -> SHOW with rd_idx=0, hold=0.
- SHOW:
  - palavra=buf[rd_idx] and palavra_valid=1, registered: valid from the first SHOW cycle.
  - hold increments every cycle.
  - At hold==HOLD_CYCLES-1, erro is sampled (the datapath is combinational, so it is settled) and err_count increments if erro=1, saturating at 2^ERR_W-1. Then hold=0, and:
    - If rd_idx<count-1: rd_idx++.
    - Else if loop_en=1 (sampled at this cycle): rd_idx=0.
    - Else -> DONE.
  - start is ignored in SHOW.
- DONE: single cycle. done=1, palavra_valid=0, then -> IDLE. The buffer is retained, so start replays it.
- Latency: start at edge N → palavra_valid=1 after edge N+1. Each word is shown exactly HOLD_CYCLES cycles. done is asserted HOLD_CYCLES*count+1 cycles after SHOW is entered.

Optional Feature:
- Macro: STOP_ON_ERROR_EN.
- Defined:
  - An erro=1 sample in SHOW also moves to state HALT. The erroneous word stays displayed (palavra_valid=1), busy=1, and err_count is incremented.
  - In HALT, start resumes SHOW at the next index, applying the same wrap/DONE rule as SHOW; clr aborts.
- Undefined: HALT does not exist, and errors are only counted.

Decomposition:
- Package sequenciador_pkg: state enum {IDLE, SHOW, DONE, HALT}; constants WORD_W=6 and CHAR_W=5; parity-bit index 0.
- One natural sub-module: temporizador_exibicao.
  - Hold counter sized by $clog2(HOLD_CYCLES).
  - Inputs: clk, rst_n, run, restart. Output: tick at the terminal count.
  - The FSM and buffer stay in sequenciador_display.

Test Plan:
- DEPTH=4, HOLD_CYCLES=4. Write 0x03, 0x05, 0x06 (even parity, erro=0), then start → palavra=0x03,0x05,0x06 for 4 cycles each; done pulses once 13 cycles after SHOW entry; err_count=0.
- Write 5 words while DEPTH=4 → wr_ready drops after the 4th; count=4; the 5th word is never displayed.
- Words 0x01 (bad parity, erro=1) and 0x03; loop_en=1 for 3 passes → display alternates with no done; err_count=3; then clr → count=0, err_count=0, palavra_valid=0 next cycle.
- rst_n pulled low mid-SHOW (hold=2) → outputs go to reset values immediately; after release, start is ignored because count=0.
- start and wr_valid asserted in the same IDLE cycle with count=2 → playback begins, count stays 2; a start during SHOW has no effect.
- With STOP_ON_ERROR_EN: sequence 0x03, 0x01, 0x05 → HALT on 0x01 with busy=1 and err_count=1; start → 0x05 shown, then done.
